lmb_bram_port_ctrl: RTL and testbench

//  Initiator side of the dual-port BRAM block port (EN/WEN/Addr/Dout out, Din in, [0:N] bit order).

---
 rtl/lmb_bram_pkg.sv | 31 +++
 rtl/lmb_bram_port_ctrl_if.sv | 37 +++
 rtl/lmb_addr_decode.sv | 24 ++
 rtl/lmb_bram_port_ctrl.sv | 110 +++++++++++
 tb/tb_lmb_bram_port_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lmb_bram_pkg.sv
// Shared definitions for the LMB-to-BRAM port controller.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package lmb_bram_pkg;

    // Controller FSM encoding; ST_RD_OREG is only reachable with LMB_BRAM_OUTREG_EN.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_OREG = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Byte lanes per word and the matching number of ignored address LSBs.
    localparam int unsigned NUM_WE    = 4;
    localparam int unsigned WORD_LSBS = $clog2(NUM_WE);

    // Clears the byte-offset bits of an address; n_we must be a power of two.
    function automatic logic [31:0] word_addr_mask(input int unsigned n_we);
        return ~(32'(n_we) - 32'd1);
    endfunction

    localparam logic [31:0] WORD_ADDR_MASK = word_addr_mask(NUM_WE);

    // Inclusive top byte address of a window, one bit wider so it cannot wrap.
    function automatic logic [32:0] window_top(input logic [31:0] base, input int unsigned size);
        return {1'b0, base} + 33'(size) - 33'd1;
    endfunction

endpackage

// File: rtl/lmb_bram_port_ctrl_if.sv
// Host request/response channel plus BRAM port signals, bit order [0:N] (bit 0 is the MSB).
// Latency: n/a (wiring only).
// Backpressure: Req_Valid/Req_Ready and Rsp_Valid/Rsp_Ready handshakes.
interface lmb_bram_port_ctrl_if #(
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = 4
);
    logic                     Req_Valid;
    logic                     Req_Ready;
    logic [0:C_NUM_WE-1]      Req_WE;
    logic [0:C_PORT_AWIDTH-1] Req_Addr;
    logic [0:C_PORT_DWIDTH-1] Req_Data;
    logic                     Rsp_Valid;
    logic                     Rsp_Ready;
    logic [0:C_PORT_DWIDTH-1] Rsp_Data;
    logic                     Rsp_Err;
    logic                     BRAM_EN;
    logic [0:C_NUM_WE-1]      BRAM_WEN;
    logic [0:C_PORT_AWIDTH-1] BRAM_Addr;
    logic [0:C_PORT_DWIDTH-1] BRAM_Dout;
    logic [0:C_PORT_DWIDTH-1] BRAM_Din;

    // Controller view: serves the host, drives the BRAM port.
    modport slave (
        input  Req_Valid, Req_WE, Req_Addr, Req_Data, Rsp_Ready, BRAM_Din,
        output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
               BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );

    // Host plus BRAM view.
    modport master (
        output Req_Valid, Req_WE, Req_Addr, Req_Data, Rsp_Ready, BRAM_Din,
        input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err,
               BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );
endinterface

// File: rtl/lmb_addr_decode.sv
// Window check: hit when C_BASEADDR <= addr <= C_BASEADDR+C_MEMSIZE-1 (unsigned, no wrap).
// Latency: combinational.
// Backpressure: none.
module lmb_addr_decode
    import lmb_bram_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter int unsigned C_MEMSIZE     = 'h2000,
    parameter int          C_PORT_AWIDTH = 32
) (
    input  logic [0:C_PORT_AWIDTH-1] addr,
    output logic                     hit
);
    localparam logic [32:0] WIN_LO = {1'b0, C_BASEADDR};
    localparam logic [32:0] WIN_HI = window_top(C_BASEADDR, C_MEMSIZE);

    logic [32:0] addr_ext;

    // Compare in 33 bits so a window ending at 0xFFFF_FFFF does not wrap.
    always_comb begin
        addr_ext = 33'(addr);
        hit      = (addr_ext >= WIN_LO) && (addr_ext <= WIN_HI);
    end
endmodule

// File: rtl/lmb_bram_port_ctrl.sv
// Host valid/ready requests to single BRAM port accesses, one outstanding; optional LMB_BRAM_OUTREG_EN.
// Latency accept->Rsp_Valid: read 3 (4 with LMB_BRAM_OUTREG_EN), write 2, out-of-window 1 cycle.
// Backpressure: Req_Ready low from accept until the response is taken; response held while Rsp_Ready=0.
module lmb_bram_port_ctrl
    import lmb_bram_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter int unsigned C_MEMSIZE     = 'h2000,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_PORT_AWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                BRAM_Clk,
    input  logic                BRAM_Rst,
    lmb_bram_port_ctrl_if.slave bus
);
    localparam logic [C_PORT_AWIDTH-1:0] ADDR_MASK = C_PORT_AWIDTH'(word_addr_mask(C_NUM_WE));

    state_t                   state, state_nxt;
    logic                     hit, accept, rsp_take, is_rd;
    logic [0:C_NUM_WE-1]      req_we;
    logic                     req_err;
    logic                     req_ready_q, rsp_valid_q, rsp_err_q, bram_en_q;
    logic [0:C_NUM_WE-1]      bram_wen_q;
    logic [0:C_PORT_AWIDTH-1] bram_addr_q;
    logic [0:C_PORT_DWIDTH-1] bram_dout_q, rsp_data_q;

    lmb_addr_decode #(
        .C_BASEADDR   (C_BASEADDR),
        .C_MEMSIZE    (C_MEMSIZE),
        .C_PORT_AWIDTH(C_PORT_AWIDTH)
    ) u_addr_decode (
        .addr(bus.Req_Addr),
        .hit (hit)
    );

    assign accept   = bus.Req_Valid && req_ready_q;
    assign rsp_take = rsp_valid_q && bus.Rsp_Ready;
    assign is_rd    = ~|req_we;

    // State register.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: in-window requests go through ACCESS, misses go straight to RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept) state_nxt = hit ? ST_ACCESS : ST_RESP;
            ST_ACCESS:  state_nxt = is_rd ? ST_RD_WAIT : ST_RESP;
`ifdef LMB_BRAM_OUTREG_EN
            ST_RD_WAIT: state_nxt = ST_RD_OREG;
`else
            ST_RD_WAIT: state_nxt = ST_RESP;
`endif
            ST_RD_OREG: state_nxt = ST_RESP;
            ST_RESP:    if (rsp_take) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and request latch; outputs follow the state one edge later, so
    // BRAM_Din (valid the cycle after the EN cycle) is sampled on the edge that raises Rsp_Valid.
    always_ff @(posedge BRAM_Clk or posedge BRAM_Rst) begin
        if (BRAM_Rst) begin
            req_ready_q <= 1'b0;
            req_we      <= '0;
            req_err     <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_wen_q  <= '0;
            bram_addr_q <= '0;
            bram_dout_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= (state_nxt == ST_IDLE);
            bram_en_q   <= (state == ST_ACCESS);
            bram_wen_q  <= (state == ST_ACCESS) ? req_we : '0;
            if (accept) begin
                req_we      <= bus.Req_WE;
                req_err     <= !hit;
                bram_addr_q <= bus.Req_Addr & ADDR_MASK;
                bram_dout_q <= bus.Req_Data;
            end
            if (state == ST_RESP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= req_err;
                    rsp_data_q  <= (is_rd && !req_err) ? bus.BRAM_Din : '0;
                end else if (bus.Rsp_Ready) begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                end
            end
        end
    end

    assign bus.Req_Ready = req_ready_q;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_Data  = rsp_data_q;
    assign bus.Rsp_Err   = rsp_err_q;
    assign bus.BRAM_EN   = bram_en_q;
    assign bus.BRAM_WEN  = bram_wen_q;
    assign bus.BRAM_Addr = bram_addr_q;
    assign bus.BRAM_Dout = bram_dout_q;
endmodule

// File: tb/tb_lmb_bram_port_ctrl.sv
// Directed bench for lmb_bram_port_ctrl with a small byte-writable BRAM model.
// Latency: checks accept-to-response latency per request type.
// Backpressure: exercises Rsp_Ready hold-off and reset in the middle of an access.
module tb_lmb_bram_port_ctrl;

`ifdef LMB_BRAM_OUTREG_EN
    localparam int RD_LAT = 4;
`else
    localparam int RD_LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lmb_bram_port_ctrl_if bus ();

    lmb_bram_port_ctrl #(
        .C_BASEADDR(32'h0000_0000),
        .C_MEMSIZE ('h2000)
    ) dut (
        .BRAM_Clk(clk),
        .BRAM_Rst(rst),
        .bus     (bus)
    );

    // BRAM model: 16 words, byte lanes big-endian (WEN[0] -> Dout[0:7]), read-first.
    logic [0:31] mem [16] = '{default: '0};
    logic [0:31] rd_q  = '0;
    logic [0:31] rd_q2 = '0;
    logic [3:0]  widx;
    assign widx = bus.BRAM_Addr[26:29];

    always @(posedge clk) begin
        if (bus.BRAM_EN) begin
            for (int b = 0; b < 4; b++)
                if (bus.BRAM_WEN[b]) mem[widx][b*8 +: 8] <= bus.BRAM_Dout[b*8 +: 8];
            rd_q <= mem[widx];
        end
        rd_q2 <= rd_q;
    end

`ifdef LMB_BRAM_OUTREG_EN
    assign bus.BRAM_Din = rd_q2;
`else
    assign bus.BRAM_Din = rd_q;
`endif

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_wen;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                                input int exp_en, input logic [31:0] exp_baddr, input logic [3:0] exp_wen);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.exp_data = exp_data; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_en = exp_en; v.exp_baddr = exp_baddr; v.exp_wen = exp_wen;
        return v;
    endfunction

    // Waits (bounded) for Req_Ready with the request already driven; returns 1 if it came.
    task automatic wait_ready(input string nm, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!bus.Req_Ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.Req_Ready) begin
            ok = 1'b0;
            total++; bad++;
            $display("FAIL %s_ready_timeout: Req_Ready got 0 expected 1", nm);
        end
    endtask

    // One request with Rsp_Ready held high: latency, EN pulses, port fields, response.
    task automatic run_vec(input vec_t v, input string nm);
        bit          ok;
        bit          got = 1'b0;
        int          lat = -1;
        int          en_cnt = 0;
        logic [31:0] baddr = '0;
        logic [3:0]  wen = '0;
        @(posedge clk); #1;
        bus.Req_Valid = 1'b1; bus.Req_WE = v.we; bus.Req_Addr = v.addr; bus.Req_Data = v.data;
        wait_ready(nm, ok);
        if (!ok) begin
            bus.Req_Valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.Req_Valid = 1'b0; bus.Req_WE = '0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (bus.BRAM_EN) begin
                en_cnt++;
                baddr = bus.BRAM_Addr;
                wen   = bus.BRAM_WEN;
            end
            if (bus.Rsp_Valid) begin
                got = 1'b1;
                lat = k - 1;
                chk({nm, "_data"}, bus.Rsp_Data, v.exp_data);
                chk({nm, "_err"}, {31'b0, bus.Rsp_Err}, {31'b0, v.exp_err});
            end
        end
        chk({nm, "_latency"}, lat, v.exp_lat);
        chk({nm, "_en_cycles"}, en_cnt, v.exp_en);
        if (v.exp_en != 0) begin
            chk({nm, "_bram_addr"}, baddr, v.exp_baddr);
            chk({nm, "_bram_wen"}, {28'b0, wen}, {28'b0, v.exp_wen});
        end
        @(posedge clk); #1;
        chk({nm, "_retired"}, {31'b0, bus.Rsp_Valid}, 32'd0);
        chk({nm, "_ready_again"}, {31'b0, bus.Req_Ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int seen;
        logic [31:0] held;

        bus.Req_Valid = 1'b0; bus.Req_WE = '0; bus.Req_Addr = '0; bus.Req_Data = '0;
        bus.Rsp_Ready = 1'b1;

        vt[0] = mk(4'b1111, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0, 2,      1, 32'h10,   4'b1111);
        vt[1] = mk(4'b0000, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0, RD_LAT, 1, 32'h10,   4'b0000);
        vt[2] = mk(4'b0000, 32'h2000,      32'h0,        32'h0,        1'b1, 1,      0, 32'h0,    4'b0000);
        vt[3] = mk(4'b1111, 32'h1FFC,      32'h12345678, 32'h0,        1'b0, 2,      1, 32'h1FFC, 4'b1111);
        vt[4] = mk(4'b0000, 32'h1FFF,      32'h0,        32'h12345678, 1'b0, RD_LAT, 1, 32'h1FFC, 4'b0000);
        vt[5] = mk(4'b0010, 32'h13,        32'hAABBCCDD, 32'h0,        1'b0, 2,      1, 32'h10,   4'b0010);
        vt[6] = mk(4'b0000, 32'h12,        32'h0,        32'hDEADCCEF, 1'b0, RD_LAT, 1, 32'h10,   4'b0000);
        vt[7] = mk(4'b1111, 32'hFFFFFFFC,  32'h0,        32'h0,        1'b1, 1,      0, 32'h0,    4'b0000);
        vt[8] = mk(4'b1000, 32'h24,        32'h11223344, 32'h0,        1'b0, 2,      1, 32'h24,   4'b1000);
        vt[9] = mk(4'b0000, 32'h24,        32'h0,        32'h11000000, 1'b0, RD_LAT, 1, 32'h24,   4'b0000);

        // Reset state, then Req_Ready one edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.Req_Ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.Rsp_Valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.Rsp_Err}, 32'd0);
        chk("rst_rsp_data", bus.Rsp_Data, 32'd0);
        chk("rst_bram_en", {31'b0, bus.BRAM_EN}, 32'd0);
        chk("rst_bram_wen", {28'b0, bus.BRAM_WEN}, 32'd0);
        chk("rst_bram_addr", bus.BRAM_Addr, 32'd0);
        chk("rst_bram_dout", bus.BRAM_Dout, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready_before_edge", {31'b0, bus.Req_Ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_ready_after_edge", {31'b0, bus.Req_Ready}, 32'd1);

        // Table-driven requests.
        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Response held off for 5 cycles while a second request waits.
        bus.Rsp_Ready = 1'b0;
        @(posedge clk); #1;
        bus.Req_Valid = 1'b1; bus.Req_WE = '0; bus.Req_Addr = 32'h10;
        wait_ready("hold", ok);
        @(posedge clk); #1;
        bus.Req_Addr = 32'h24;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.Rsp_Valid) seen = 1;
        end
        chk("hold_rsp_arrived", seen, 1);
        held = 32'hDEADCCEF;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", k), {31'b0, bus.Rsp_Valid}, 32'd1);
            chk($sformatf("hold%0d_data", k), bus.Rsp_Data, held);
            chk($sformatf("hold%0d_req_ready", k), {31'b0, bus.Req_Ready}, 32'd0);
            if (bus.BRAM_EN) seen++;
        end
        chk("hold_no_new_access", seen, 0);
        bus.Req_Valid = 1'b0;
        bus.Rsp_Ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_retired", {31'b0, bus.Rsp_Valid}, 32'd0);
        chk("hold_ready_again", {31'b0, bus.Req_Ready}, 32'd1);

        // Reset while the write's EN cycle is on the port: access dropped, no response.
        @(posedge clk); #1;
        bus.Req_Valid = 1'b1; bus.Req_WE = 4'b1111; bus.Req_Addr = 32'h28; bus.Req_Data = 32'h55555555;
        wait_ready("midrst", ok);
        @(posedge clk); #1;
        bus.Req_Valid = 1'b0; bus.Req_WE = '0;
        @(posedge clk); #1;
        chk("midrst_en_before", {31'b0, bus.BRAM_EN}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_en_dropped", {31'b0, bus.BRAM_EN}, 32'd0);
        chk("midrst_wen_dropped", {28'b0, bus.BRAM_WEN}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.Rsp_Valid) seen++;
        end
        chk("midrst_no_response", seen, 0);
        chk("midrst_ready", {31'b0, bus.Req_Ready}, 32'd1);
        run_vec(mk(4'b0000, 32'h28, 32'h0, 32'h0, 1'b0, RD_LAT, 1, 32'h28, 4'b0000), "post_rst_dropped_write");
        run_vec(mk(4'b0000, 32'h10, 32'h0, 32'hDEADCCEF, 1'b0, RD_LAT, 1, 32'h10, 4'b0000), "post_rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
